// File: rtl/neighbor_validator_stream.sv
// Streaming neighbour-count point validator: classifies a query point as inlier/outlier
// by counting candidates within an inclusive L1 or L-inf radius, with early exit on threshold.
module neighbor_validator_stream #(
  parameter int N                = 16,
  parameter int DISTANCE_MODULES = 8,
  parameter int CNT_W            = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          metric,
  input  logic [N-1:0]                  point_x,
  input  logic [N-1:0]                  point_y,
  input  logic [N-1:0]                  point_z,
  input  logic [2*N-1:0]                point_cloud_size,
  input  logic [N+2:0]                  search_radius,
  input  logic [CNT_W-1:0]              neighbor_threshold,
  input  logic                          cp_valid,
  output logic                          cp_ready,
  input  logic [N*DISTANCE_MODULES-1:0] cp_x,
  input  logic [N*DISTANCE_MODULES-1:0] cp_y,
  input  logic [N*DISTANCE_MODULES-1:0] cp_z,
  input  logic [DISTANCE_MODULES-1:0]   cp_mask,
  output logic                          busy,
  output logic                          done,
  output logic                          inlier,
  output logic                          outlier,
  output logic [CNT_W-1:0]              neighbor_count
);

  localparam int DM = DISTANCE_MODULES;
  localparam int AW = N + 1;
  localparam int DW = N + 3;
  localparam int CW = 2 * N;
  localparam int PW = $clog2(DM + 1);
  localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               r_state, w_stateNext;
  logic                 r_metric;
  logic [N-1:0]         r_px, r_py, r_pz;
  logic [CW-1:0]        r_size, r_consumed;
  logic [DW-1:0]        r_radius;
  logic [CNT_W-1:0]     r_thr, r_count;
  logic                 r_inlier, r_outlier;

  logic                 r_s1Valid, r_s2Valid;
  logic [DM-1:0]        r_s1Lane, r_s2Lane;
  logic [DM-1:0][AW-1:0] r_s1Ax, r_s1Ay, r_s1Az;
  logic [DM-1:0][DW-1:0] r_s2Dist;

  logic [CW-1:0]        w_remaining, w_take;
  logic [DM-1:0]        w_laneOk, w_hitLane;
  logic [PW-1:0]        w_pop;
  logic [SW-1:0]        w_sum;
  logic [CNT_W-1:0]     w_countNext;
  logic                 w_active, w_hit, w_drained, w_accept, w_flush;

  // Magnitude of a signed coordinate difference; one extra bit holds the full range.
  function automatic logic [AW-1:0] absDiff(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [AW-1:0] d;
    d = {a[N-1], a} - {b[N-1], b};
    return d[AW-1] ? (~d + AW'(1)) : d;
  endfunction

  function automatic logic [DW-1:0] laneDist(input logic useMax, input logic [AW-1:0] ax,
                                             input logic [AW-1:0] ay, input logic [AW-1:0] az);
    logic [AW-1:0] m;
    m = (ax > ay) ? ax : ay;
    m = (m > az) ? m : az;
    return useMax ? DW'(m) : (DW'(ax) + DW'(ay) + DW'(az));
  endfunction

  always_comb begin
    w_remaining = r_size - r_consumed;
    w_take      = (w_remaining < CW'(DM)) ? w_remaining : CW'(DM);
    w_laneOk    = '0;
    w_hitLane   = '0;
    w_pop       = '0;
    for (int j = 0; j < DM; j++) begin
      w_laneOk[j]  = cp_mask[j] && (w_remaining > CW'(j));
      w_hitLane[j] = r_s2Valid && r_s2Lane[j] && (r_s2Dist[j] <= r_radius);
      w_pop        = w_pop + PW'(w_hitLane[j]);
    end
    w_sum       = SW'(r_count) + SW'(w_pop);
    w_countNext = (w_sum > SW'(CNT_MAX)) ? CNT_MAX : w_sum[CNT_W-1:0];
    w_active    = (r_state == RUN) || (r_state == DRAIN);
    w_hit       = w_active && (w_countNext >= r_thr);
    w_drained   = !r_s1Valid && !r_s2Valid;
    cp_ready    = (r_state == RUN) && !w_hit && (r_consumed < r_size);
    w_accept    = cp_valid && cp_ready;
  end

  // Threshold hit takes priority over running out of candidates, so inlier wins ties.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (start) w_stateNext = RUN;
      RUN:     if (w_hit) w_stateNext = DONE;
               else if (r_consumed >= r_size) w_stateNext = DRAIN;
      DRAIN:   if (w_hit || w_drained) w_stateNext = DONE;
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
    if (abort) w_stateNext = IDLE;
    w_flush = (w_stateNext != RUN) && (w_stateNext != DRAIN);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_metric   <= 1'b0;
      r_px       <= '0;
      r_py       <= '0;
      r_pz       <= '0;
      r_size     <= '0;
      r_consumed <= '0;
      r_radius   <= '0;
      r_thr      <= '0;
      r_count    <= '0;
      r_inlier   <= 1'b0;
      r_outlier  <= 1'b0;
      r_s1Valid  <= 1'b0;
      r_s2Valid  <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_s1Valid <= w_accept && !w_flush;
      r_s2Valid <= r_s1Valid && !w_flush;
      if (abort) begin
        r_count   <= '0;
        r_inlier  <= 1'b0;
        r_outlier <= 1'b0;
      end else if ((r_state == IDLE) && start) begin
        r_metric   <= metric;
        r_px       <= point_x;
        r_py       <= point_y;
        r_pz       <= point_z;
        r_size     <= point_cloud_size;
        r_radius   <= search_radius;
        r_thr      <= neighbor_threshold;
        r_consumed <= '0;
        r_count    <= '0;
        r_inlier   <= 1'b0;
        r_outlier  <= 1'b0;
      end else begin
        if (w_active) r_count <= w_countNext;
        if (w_accept) r_consumed <= r_consumed + w_take;
        if (w_active && (w_stateNext == DONE)) begin
          r_inlier  <= w_hit;
          r_outlier <= !w_hit;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_s1Lane <= w_laneOk;
      for (int j = 0; j < DM; j++) begin
        r_s1Ax[j] <= absDiff(cp_x[j*N +: N], r_px);
        r_s1Ay[j] <= absDiff(cp_y[j*N +: N], r_py);
        r_s1Az[j] <= absDiff(cp_z[j*N +: N], r_pz);
      end
    end
    r_s2Lane <= r_s1Lane;
    for (int j = 0; j < DM; j++) begin
      r_s2Dist[j] <= laneDist(r_metric, r_s1Ax[j], r_s1Ay[j], r_s1Az[j]);
    end
  end

  assign busy           = (r_state != IDLE);
  assign done           = (r_state == DONE);
  assign inlier         = r_inlier;
  assign outlier        = r_outlier;
  assign neighbor_count = r_count;

endmodule

// File: tb/tb_neighbor_validator_stream.sv
// Randomised scoreboard bench for neighbor_validator_stream: a full-width instance (A)
// and a 3-bit-counter instance (B) share stimulus buses but have separate start lines.
module tb_neighbor_validator_stream;

   localparam int N   = 16;
   localparam int DM  = 8;

   typedef struct {
      bit inl;
      bit outl;
      int cnt;
   } expT;

   logic clock;
   logic reset;
   logic startA, startB, abort, metric;
   logic [N-1:0] pointX, pointY, pointZ;
   logic [2*N-1:0] cloudSize;
   logic [N+2:0] radius;
   logic [15:0] thrA;
   logic [2:0] thrB;
   logic cpValid;
   logic [N*DM-1:0] cpX, cpY, cpZ;
   logic [DM-1:0] cpMask;
   logic readyA, busyA, doneA, inlierA, outlierA;
   logic readyB, busyB, doneB, inlierB, outlierB;
   logic [15:0] countA;
   logic [2:0] countB;

   int checks = 0;
   int errors = 0;
   expT expA[$];
   expT expB[$];
   expT popA, popB;
   logic [N*DM-1:0] bx[$], by[$], bz[$];
   logic [DM-1:0] bm[$];

   neighbor_validator_stream #(.N(N), .DISTANCE_MODULES(DM), .CNT_W(16)) dutA (
      .clock(clock), .reset(reset), .start(startA), .abort(abort), .metric(metric),
      .point_x(pointX), .point_y(pointY), .point_z(pointZ),
      .point_cloud_size(cloudSize), .search_radius(radius), .neighbor_threshold(thrA),
      .cp_valid(cpValid), .cp_ready(readyA), .cp_x(cpX), .cp_y(cpY), .cp_z(cpZ),
      .cp_mask(cpMask), .busy(busyA), .done(doneA), .inlier(inlierA), .outlier(outlierA),
      .neighbor_count(countA));

   neighbor_validator_stream #(.N(N), .DISTANCE_MODULES(DM), .CNT_W(3)) dutB (
      .clock(clock), .reset(reset), .start(startB), .abort(abort), .metric(metric),
      .point_x(pointX), .point_y(pointY), .point_z(pointZ),
      .point_cloud_size(cloudSize), .search_radius(radius), .neighbor_threshold(thrB),
      .cp_valid(cpValid), .cp_ready(readyB), .cp_x(cpX), .cp_y(cpY), .cp_z(cpZ),
      .cp_mask(cpMask), .busy(busyB), .done(doneB), .inlier(inlierB), .outlier(outlierB),
      .neighbor_count(countB));

   // Free-running clock, 10 time units per period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single point of comparison so every check is counted the same way.
   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
      end
   endtask

   function automatic int absInt(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int clampCoord(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // Monitor: whenever a DUT signals done, pop its oldest expected result and compare.
   always @(negedge clock) begin
      if (doneA) begin
         if (expA.size() == 0) checkOutput("unexpectedDoneA", 1, 0);
         else begin
            popA = expA.pop_front();
            checkOutput("inlierA", int'(inlierA), int'(popA.inl));
            checkOutput("outlierA", int'(outlierA), int'(popA.outl));
            checkOutput("countA", int'(countA), popA.cnt);
         end
      end
      if (doneB) begin
         if (expB.size() == 0) checkOutput("unexpectedDoneB", 1, 0);
         else begin
            popB = expB.pop_front();
            checkOutput("inlierB", int'(inlierB), int'(popB.inl));
            checkOutput("outlierB", int'(outlierB), int'(popB.outl));
            checkOutput("countB", int'(countB), popB.cnt);
         end
      end
   end

   // Builds one query (mode 0 random near point, 1 extreme coords, 2 fixed offset all lanes,
   // 3 fixed offset alternate lanes), predicts the result, then drives it through handshakes.
   task automatic applyStimulus(input bit sel, input int thr, input int size, input int rad,
                                input bit met, input int mode, input int spread,
                                input bit alwaysValid, input int expLat);
      int px, py, pz, cx, cy, cz, nb, cnt, cmax, pop, d, idx, doneIt;
      int cand;
      bit inl, fire, bsy, finished;
      logic [N*DM-1:0] vx, vy, vz;
      logic [DM-1:0] m;
      int pops[$];
      expT e;

      if (mode == 1) begin
         px = $urandom_range(1) ? 32767 : -32768;
         py = $urandom_range(1) ? 32767 : -32768;
         pz = $urandom_range(1) ? 32767 : -32768;
      end else begin
         px = int'($urandom_range(40000)) - 20000;
         py = int'($urandom_range(40000)) - 20000;
         pz = int'($urandom_range(40000)) - 20000;
      end
      bx.delete(); by.delete(); bz.delete(); bm.delete();
      nb = (size + DM - 1) / DM;
      for (int b = 0; b < nb; b++) begin
         pop = 0;
         m = (mode == 2) ? 8'hFF : (mode == 3) ? 8'h55 : 8'($urandom_range(255));
         for (int j = 0; j < DM; j++) begin
            if (mode == 1) begin
               cx = $urandom_range(1) ? 32767 : -32768;
               cy = $urandom_range(1) ? 32767 : -32768;
               cz = $urandom_range(1) ? 32767 : -32768;
            end else if (mode >= 2) begin
               cx = px + spread; cy = py - spread; cz = pz + spread;
            end else begin
               cx = clampCoord(px + int'($urandom_range(2 * spread)) - spread);
               cy = clampCoord(py + int'($urandom_range(2 * spread)) - spread);
               cz = clampCoord(pz + int'($urandom_range(2 * spread)) - spread);
            end
            vx[j*N +: N] = 16'(cx);
            vy[j*N +: N] = 16'(cy);
            vz[j*N +: N] = 16'(cz);
            if (met) begin
               d = absInt(cx - px);
               if (absInt(cy - py) > d) d = absInt(cy - py);
               if (absInt(cz - pz) > d) d = absInt(cz - pz);
            end else d = absInt(cx - px) + absInt(cy - py) + absInt(cz - pz);
            cand = b * DM + j;
            if (cand < size && m[j] && d <= rad) pop++;
         end
         bx.push_back(vx); by.push_back(vy); bz.push_back(vz); bm.push_back(m);
         pops.push_back(pop);
      end

      cmax = sel ? 7 : 65535;
      cnt = 0;
      inl = (thr == 0);
      if (!inl) begin
         foreach (pops[b]) begin
            cnt = (cnt + pops[b] > cmax) ? cmax : cnt + pops[b];
            if (cnt >= thr) begin
               inl = 1'b1;
               break;
            end
         end
      end
      e.inl = inl; e.outl = !inl; e.cnt = cnt;
      if (sel) expB.push_back(e); else expA.push_back(e);

      @(posedge clock); #1;
      metric = met;
      pointX = 16'(px); pointY = 16'(py); pointZ = 16'(pz);
      cloudSize = 32'(size);
      radius = 19'(rad);
      thrA = 16'(thr);
      thrB = 3'(thr);
      if (sel) startB = 1'b1; else startA = 1'b1;
      @(posedge clock); #1;
      startA = 1'b0; startB = 1'b0;

      idx = 0; doneIt = -1; finished = 1'b0;
      for (int it = 0; it < 4000; it++) begin
         if (idx < nb && (alwaysValid || $urandom_range(3) != 0)) begin
            cpValid = 1'b1;
            cpX = bx[idx]; cpY = by[idx]; cpZ = bz[idx]; cpMask = bm[idx];
         end else begin
            cpValid = 1'b0;
            cpMask = 8'($urandom_range(255));
         end
         @(negedge clock);
         fire = cpValid && (sel ? readyB : readyA);
         if ((sel ? doneB : doneA) && doneIt < 0) doneIt = it;
         bsy = sel ? busyB : busyA;
         @(posedge clock); #1;
         if (fire) idx++;
         if (!bsy) begin
            finished = 1'b1;
            break;
         end
      end
      cpValid = 1'b0;
      if (!finished) checkOutput("queryTimeout", 0, 1);
      if (expLat >= 0) checkOutput("doneLatency", doneIt, expLat);
   endtask

   // Starts a long all-hit query on A, then cancels it by abort or by reset.
   task automatic applyInterrupt(input bit useReset);
      @(posedge clock); #1;
      metric = 1'b0;
      pointX = '0; pointY = '0; pointZ = '0;
      cloudSize = 32'd1000; radius = 19'd10; thrA = 16'hFFFF;
      cpX = '0; cpY = '0; cpZ = '0; cpMask = 8'hFF;
      startA = 1'b1;
      @(posedge clock); #1;
      startA = 1'b0;
      cpValid = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      if (useReset) reset = 1'b0; else abort = 1'b1;
      @(posedge clock); #1;
      reset = 1'b1; abort = 1'b0; cpValid = 1'b0;
      @(negedge clock);
      checkOutput(useReset ? "rstBusy" : "abortBusy", int'(busyA), 0);
      checkOutput(useReset ? "rstInlier" : "abortInlier", int'(inlierA), 0);
      checkOutput(useReset ? "rstOutlier" : "abortOutlier", int'(outlierA), 0);
      checkOutput(useReset ? "rstCount" : "abortCount", int'(countA), 0);
      checkOutput(useReset ? "rstReady" : "abortReady", int'(readyA), 0);
      repeat (10) @(posedge clock);
   endtask

   initial begin
      reset = 1'b0;
      startA = 1'b0; startB = 1'b0; abort = 1'b0; metric = 1'b0;
      pointX = '0; pointY = '0; pointZ = '0;
      cloudSize = '0; radius = '0; thrA = '0; thrB = '0;
      cpValid = 1'b0; cpX = '0; cpY = '0; cpZ = '0; cpMask = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      checkOutput("resetBusy", int'(busyA), 0);
      checkOutput("resetDone", int'(doneA), 0);
      checkOutput("resetReady", int'(readyA), 0);
      checkOutput("resetInlier", int'(inlierA), 0);
      checkOutput("resetOutlier", int'(outlierA), 0);
      checkOutput("resetCount", int'(countA), 0);
      @(posedge clock); #1;
      reset = 1'b1;

      // sel, thr, size, rad, met, mode, spread, alwaysValid, expLat
      applyStimulus(0, 3, 16, 10, 0, 2, 7, 1, 5);
      applyStimulus(0, 4, 64, 5, 0, 3, 1, 1, 3);
      applyStimulus(0, 6, 5, 10, 0, 2, 0, 1, 4);
      applyStimulus(0, 8, 8, 6, 1, 2, 4, 1, 3);
      applyStimulus(0, 8, 8, 6, 0, 2, 4, 1, 4);
      applyStimulus(0, 1, 8, 15, 0, 2, 5, 1, 3);
      applyStimulus(0, 1, 8, 14, 0, 2, 5, 1, 4);
      applyStimulus(0, 0, 32, 100, 0, 2, 0, 1, 1);
      applyStimulus(0, 5, 0, 100, 0, 2, 0, 1, 2);
      applyStimulus(0, 20, 24, 65535, 1, 1, 0, 0, -1);
      applyStimulus(0, 20, 24, 196605, 0, 1, 0, 0, -1);
      applyStimulus(1, 7, 16, 10, 0, 2, 0, 1, 3);
      applyStimulus(1, 7, 40, 10, 0, 3, 0, 1, -1);

      applyInterrupt(0);
      applyInterrupt(1);

      for (int q = 0; q < 40; q++) begin
         if ($urandom_range(3) == 0)
            applyStimulus(1, $urandom_range(7), $urandom_range(60), $urandom_range(3000),
                          1'($urandom_range(1)), 0, $urandom_range(2000), 0, -1);
         else
            applyStimulus(0, ($urandom_range(9) == 0) ? 0 : $urandom_range(1, 40),
                          $urandom_range(80), $urandom_range(3000), 1'($urandom_range(1)),
                          ($urandom_range(7) == 0) ? 1 : 0, $urandom_range(2000), 0, -1);
      end

      repeat (5) @(posedge clock);
      checkOutput("pendingA", expA.size(), 0);
      checkOutput("pendingB", expB.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
